// File: rtl/shifter.sv
// Video shift stage.
//
// Sits between the line-buffer feeder and the palette lookup. Each word the
// feeder presents with load_i is captured into a shift register and emitted
// MSB-first as 1, 2, 4 or 8 bit pixel indices, one per dot clock. The field
// is zero-extended to PW bits. Outside active scanline time the border
// colour index is emitted instead.
//
// Timing, in dot-clock edges:
//   - A word loaded at edge N gives its first field on pixel_o after edge N+1.
//   - Later fields follow one per edge.
//   - pixel_o/active_o lag scanline_en_i by two edges, which lines up with the
//     feeder's registered load/address path.
//
// The feeder reloads every 16/8/4/2 dots for 1/2/4/8bpp, so the register is
// empty exactly when the next word lands. When a load comes early, the fields
// still unsent are thrown away. When a load comes late, zero fields come out
// until it arrives.
//
// DW must be 16 to match the feeder cadence. PW must be at least 8 so that an
// 8bpp field fits.

module shifter #(
  parameter int DW = 16,
  parameter int PW = 8
) (
  input  logic          dotclk_i,
  input  logic          reset_n_i,
  input  logic          scanline_en_i,
  input  logic          load_i,
  input  logic [DW-1:0] f_dat_i,
  input  logic          shift1_i,
  input  logic          shift2_i,
  input  logic          shift4_i,
  input  logic          shift8_i,
  input  logic [PW-1:0] border_i,
  output logic [PW-1:0] pixel_o,
  output logic          active_o
);

  // Bits per pixel. The encoding order is only used for readability.
  typedef enum logic [1:0] {
    MODE_1BPP = 2'd0,
    MODE_2BPP = 2'd1,
    MODE_4BPP = 2'd2,
    MODE_8BPP = 2'd3
  } mode_e;

  mode_e         mode_dec;
  mode_e         mode_d;
  mode_e         mode_q;

  logic [DW-1:0] sr_d;
  logic [DW-1:0] sr_q;

  logic          en_d;
  logic          en_q;

  logic [PW-1:0] field;
  logic [PW-1:0] pixel_d;
  logic [PW-1:0] pixel_q;
  logic          active_d;
  logic          active_q;

  // shift1_i is the fall-through case. It is not decoded explicitly, but it
  // is kept as a port so the feeder's mode bus connects one-to-one.
  logic          unused_shift1;
  assign unused_shift1 = shift1_i;

  // Decode the mode. Priority is 8bpp > 4bpp > 2bpp, and anything else is
  // 1bpp. This also settles the cases where no bit or several bits are set.
  always_comb begin
    mode_dec = MODE_1BPP;
    if (shift8_i) begin
      mode_dec = MODE_8BPP;
    end else if (shift4_i) begin
      mode_dec = MODE_4BPP;
    end else if (shift2_i) begin
      mode_dec = MODE_2BPP;
    end
  end

  // Latch the mode only together with a word. A mode change in the middle of
  // a word therefore takes effect from the next word.
  always_comb begin
    mode_d = mode_q;
    if (load_i) begin
      mode_d = mode_dec;
    end
  end

  // Shift register next state. Load wins over shift. The shift amount follows
  // the mode latched with the current word, and the low bits are zero-filled.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = f_dat_i;
    end else begin
      case (mode_q)
        MODE_1BPP: sr_d = {sr_q[DW-2:0], 1'b0};
        MODE_2BPP: sr_d = {sr_q[DW-3:0], 2'b00};
        MODE_4BPP: sr_d = {sr_q[DW-5:0], 4'h0};
        MODE_8BPP: sr_d = {sr_q[DW-9:0], 8'h00};
        default:   sr_d = {sr_q[DW-2:0], 1'b0};
      endcase
    end
  end

  // Take the top field of the shift register and zero-extend it to PW bits.
  always_comb begin
    field = '0;
    case (mode_q)
      MODE_1BPP: field[0]   = sr_q[DW-1];
      MODE_2BPP: field[1:0] = sr_q[DW-1 -: 2];
      MODE_4BPP: field[3:0] = sr_q[DW-1 -: 4];
      MODE_8BPP: field[7:0] = sr_q[DW-1 -: 8];
      default:   field[0]   = sr_q[DW-1];
    endcase
  end

  // Scanline enable is delayed one edge so that it lines up with the data
  // the feeder has just registered.
  always_comb begin
    en_d = scanline_en_i;
  end

  // Output select. Pixel data goes out while the delayed enable is high, and
  // the border colour goes out otherwise. border_i is sampled on every
  // non-active edge.
  always_comb begin
    pixel_d  = border_i;
    active_d = 1'b0;
    if (en_q) begin
      pixel_d  = field;
      active_d = 1'b1;
    end
  end

  // State and output registers. The asynchronous reset clears everything at
  // once, even in the middle of a word.
  always_ff @(posedge dotclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sr_q     <= '0;
      mode_q   <= MODE_1BPP;
      en_q     <= 1'b0;
      pixel_q  <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      pixel_q  <= pixel_d;
      active_q <= active_d;
    end
  end

  assign pixel_o  = pixel_q;
  assign active_o = active_q;

endmodule

// File: tb/tb_shifter.sv
// Testbench for the video shift stage.
//
// The reference model does not shift anything. It remembers the last word
// loaded, the pixel width latched with it, and how many fields have been
// consumed since the load. The expected field is then computed arithmetically
// from the word. The scanline enable is delayed by one step to give the
// two-edge output latency.

module tb_shifter;

  localparam int DW = 16;
  localparam int PW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          scanline_en;
  logic          load;
  logic [DW-1:0] f_dat;
  logic          shift1, shift2, shift4, shift8;
  logic [PW-1:0] border;
  logic [PW-1:0] pixel_o;
  logic          active_o;

  always #5 clk = ~clk;

  shifter #(.DW(DW), .PW(PW)) dut (
    .dotclk_i      (clk),
    .reset_n_i     (reset_n),
    .scanline_en_i (scanline_en),
    .load_i        (load),
    .f_dat_i       (f_dat),
    .shift1_i      (shift1),
    .shift2_i      (shift2),
    .shift4_i      (shift4),
    .shift8_i      (shift8),
    .border_i      (border),
    .pixel_o       (pixel_o),
    .active_o      (active_o)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_word;
  int            m_bits;
  int            m_idx;
  logic          m_en;
  logic [PW-1:0] e_pix;
  logic          e_act;

  function automatic int dec_bits(logic s8, logic s4, logic s2);
    if (s8) return 8;
    if (s4) return 4;
    if (s2) return 2;
    return 1;
  endfunction

  // Field number idx (0 = most significant) of a word split into n-bit
  // fields. Any field beyond the end of the word is zero.
  function automatic logic [PW-1:0] field_of(logic [DW-1:0] w, int n, int idx);
    int top;
    int val;
    top = (idx + 1) * n;
    if (top > DW) return '0;
    val = (int'(w) >> (DW - top)) & ((1 << n) - 1);
    return PW'(val);
  endfunction

  function automatic void model_reset();
    m_word = '0;
    m_bits = 1;
    m_idx  = 0;
    m_en   = 1'b0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_mode(input int bpp);
    shift1 = (bpp == 1);
    shift2 = (bpp == 2);
    shift4 = (bpp == 4);
    shift8 = (bpp == 8);
  endtask

  // Advance one edge. The model is updated from the inputs as they stand
  // before the edge, then both outputs are compared shortly after the edge.
  task automatic tick();
    if (m_en) begin
      e_pix = field_of(m_word, m_bits, m_idx);
      e_act = 1'b1;
    end else begin
      e_pix = border;
      e_act = 1'b0;
    end
    if (load) begin
      m_word = f_dat;
      m_bits = dec_bits(shift8, shift4, shift2);
      m_idx  = 0;
    end else if (m_idx < DW) begin
      m_idx++;
    end
    m_en = scanline_en;
    @(posedge clk);
    #1;
    chk("model_pix", pixel_o, e_pix);
    chk("model_act", {7'b0, active_o}, {7'b0, e_act});
  endtask

  // Assert reset between edges, check the outputs clear at once, then
  // release between edges.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_pix_now", pixel_o, 8'h00);
    chk("rst_act_now", {7'b0, active_o}, 8'h00);
    model_reset();
    @(posedge clk);
    #3;
    chk("rst_pix_hold", pixel_o, 8'h00);
    reset_n = 1'b1;
  endtask

  // ---------------- directed steps + random ----------------
  logic [PW-1:0] exp_seq[16];
  logic [PW-1:0] got;

  initial begin
    reset_n     = 1'b0;
    scanline_en = 1'b0;
    load        = 1'b0;
    f_dat       = '0;
    border      = '0;
    set_mode(1);
    model_reset();
    #12;
    chk("reset_pix", pixel_o, 8'h00);
    chk("reset_act", {7'b0, active_o}, 8'h00);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // 1: reset in the middle of a word. sr holds FFFF, so 1bpp output is 1.
    scanline_en = 1'b1;
    load = 1'b1; f_dat = 16'hFFFF; set_mode(1);
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("pre_rst_pix", pixel_o, 8'h01);
    async_reset();
    tick();  // first edge after release: en_q was cleared, so border comes out
    chk("post_rst_act", {7'b0, active_o}, 8'h00);

    // 2: 1bpp A5C3
    exp_seq = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1,
                8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    load = 1'b1; f_dat = 16'hA5C3; set_mode(1);
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("bpp1_pix", pixel_o, exp_seq[i]);
      chk("bpp1_act", {7'b0, active_o}, 8'h01);
    end

    // 3: 8bpp, two words back to back
    exp_seq[0] = 8'h12; exp_seq[1] = 8'hF0; exp_seq[2] = 8'h7E; exp_seq[3] = 8'h81;
    set_mode(8);
    load = 1'b1; f_dat = 16'h12F0; tick();
    load = 1'b0; tick(); chk("bpp8_pix", pixel_o, exp_seq[0]);
    load = 1'b1; f_dat = 16'h7E81; tick(); chk("bpp8_pix", pixel_o, exp_seq[1]);
    load = 1'b0; tick(); chk("bpp8_pix", pixel_o, exp_seq[2]);
    tick(); chk("bpp8_pix", pixel_o, exp_seq[3]);

    // 4: 2bpp with 4bpp requested in the middle of the word; the new mode
    //    applies from the next word.
    exp_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3,
                8'hA, 8'hB, 8'hC, 8'hD, 8'd0, 8'd0, 8'd0, 8'd0};
    set_mode(2);
    load = 1'b1; f_dat = 16'h1B1B; tick();
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) shift4 = 1'b1;
      load = (i == 7);
      if (i == 7) f_dat = 16'hABCD;
      tick();
      chk("bpp2_4_pix", pixel_o, exp_seq[i]);
    end
    load = 1'b0;

    // 5: blanking with load held high and the data changing
    scanline_en = 1'b0; border = 8'h2C; load = 1'b1; set_mode(4);
    for (int i = 0; i < 6; i++) begin
      f_dat = 16'($urandom);
      tick();
      if (i >= 2) begin
        chk("blank_pix", pixel_o, 8'h2C);
        chk("blank_act", {7'b0, active_o}, 8'h00);
      end
    end
    border = 8'h3D; tick(); chk("border_chg", pixel_o, 8'h3D);
    scanline_en = 1'b1; f_dat = 16'h5E21; tick();
    chk("rise_act0", {7'b0, active_o}, 8'h00);
    load = 1'b0; tick();
    chk("rise_act1", {7'b0, active_o}, 8'h01);
    chk("rise_pix1", pixel_o, 8'h05);

    // 6: late load in 4bpp
    exp_seq = '{8'h9, 8'hA, 8'h5, 8'hF, 8'h0, 8'h0, 8'hC, 8'h3,
                8'hE, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    set_mode(4);
    load = 1'b1; f_dat = 16'h9A5F; tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load = (i == 5);
      if (i == 5) f_dat = 16'hC3E1;
      tick();
      got = pixel_o;
      chk("late_pix", got, exp_seq[i]);
    end
    load = 1'b0;

    // Random traffic checked against the model
    for (int i = 0; i < 800; i++) begin
      load        = ($urandom_range(0, 9) < 2);
      f_dat       = 16'($urandom);
      shift2      = 1'($urandom_range(0, 1));
      shift4      = 1'($urandom_range(0, 1));
      shift8      = ($urandom_range(0, 3) == 0);
      shift1      = 1'($urandom_range(0, 1));
      scanline_en = ($urandom_range(0, 15) != 0);
      border      = 8'($urandom);
      if (i == 400) async_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter.md
Name: shifter

Overview:
- Video shift stage directly downstream of the line-buffer fetch stage (the feeder).
- Captures each line-buffer word when the feeder's load pulse is high, then serializes it MSB-first into 1/2/4/8-bit pixel indices, one pixel per dot clock.
- Outside active scanline time it emits a border colour index.
- Output goes to the palette lookup.

Parameters:
- DW, 16: line-buffer word width in bits. Must equal 16 to match the feeder's reload cadence; other values unsupported.
- PW, 8: pixel index output width. Narrower fields are zero-extended to this width.

Ports:
- dotclk_i  input  1  dot clock; all state changes on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- scanline_en_i  input  1  1 while refreshing a scanline; same signal that drives the feeder.
- load_i  input  1  feeder load pulse; 1 = capture f_dat_i this edge.
- f_dat_i  input  DW  line-buffer word at the feeder's current fetch address; asynchronous read, valid in the cycle load_i=1.
- shift1_i  input  1  1bpp mode.
- shift2_i  input  1  2bpp mode.
- shift4_i  input  1  4bpp mode.
- shift8_i  input  1  8bpp mode.
- border_i  input  PW  border colour index.
- pixel_o  output  PW  pixel index to palette.
- active_o  output  1  1 when pixel_o carries scanline pixel data, 0 when it carries border.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - sr=0, mode_q=1bpp, en_q=0, pixel_o=0, active_o=0.
  - Takes effect immediately regardless of the clock and may occur mid-word. First edge after release behaves as a normal edge.
- Mode decode, priority: shift8_i > shift4_i > shift2_i > otherwise 1bpp. This also covers none or several asserted.
- Mode latch: mode_q <= decoded mode only on edges where load_i=1. A mode change mid-word therefore takes effect from the next word.
- Shift register sr[DW-1:0], each rising edge:
  - if load_i: sr <= f_dat_i
  - else: sr <= sr << n, where n = 1/2/4/8 per mode_q; low bits zero-filled.
- Field extract (combinational): field = sr[DW-1 -: n] per mode_q, zero-extended to PW.
- Enable pipeline: en_q <= scanline_en_i each edge.
- Output register, each edge:
  - if en_q: pixel_o <= field and active_o <= 1
  - else: pixel_o <= border_i and active_o <= 0
- Latency:
  - A word captured at edge N yields its first field on pixel_o after edge N+1.
  - Subsequent fields appear one per edge.
  - active_o and pixel_o lag scanline_en_i by 2 edges. This matches the feeder's registered load/address, so no pixel is dropped or duplicated.
- Cadence contract: the feeder reloads every 16/8/4/2 dots in 1/2/4/8bpp. sr is exactly emptied when the next load arrives.
- Early load: sr is overwritten and the remaining fields are discarded.
- Late load: zero fields (index 0) are emitted until the next load.
- load_i=1 continuously (feeder holds it during blanking): sr tracks f_dat_i every edge and nothing shifts.
- scanline_en_i falling mid-word: border takes over 2 edges later; sr contents are discarded by subsequent loads.
- border_i is sampled every non-active edge, so changes during blanking are visible with 1-edge latency.

Test Plan:
1. Reset mid-word with sr=16'hFFFF, async assert between edges → pixel_o=0 and active_o=0 immediately, before any clock edge; first edge after release behaves normally.
2. 1bpp:
   - Stimulus: load 16'hA5C3 at edge N, scanline_en_i high, no load for 15 edges.
   - Required: pixel_o after edges N+1..N+16 = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; active_o=1.
3. 8bpp: load 16'h12F0, then 16'h7E81 two edges later → pixel_o sequence 8'h12, 8'hF0, 8'h7E, 8'h81 on consecutive edges.
4. 2bpp then 4bpp:
   - Stimulus: load 16'h1B1B in 2bpp, assert shift4_i after 3 shifts.
   - Required: fields 0,1,2,3,0,1,2,3 (mode unchanged mid-word); the next load of 16'hABCD yields A,B,C,D.
5. Blanking:
   - Stimulus: scanline_en_i=0, border_i=8'h2C, load_i=1 continuously, f_dat_i varying.
   - Required: pixel_o=8'h2C, active_o=0. After scanline_en_i rises, active_o=1 exactly 2 edges later with the first field of the word present at the rise.
6. Late load in 4bpp: after 4 fields, withhold load for 2 edges → two pixel_o=0 fields, then normal output resumes from the new word.
